// File: rtl/tank_decoder_seq.sv
// Sequential dual-rail tank address decoder: latches a transfer request and holds
// a one-hot tank select for one minor cycle. Optional macro TANK_DECODER_LONG_EN adds long-word transfers.
module tank_decoder_seq #(
  parameter int ADDR_BITS = 2,
  parameter int WORD_TIME = 18,
  parameter int CNT_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_BITS-1:0]    addr_pos,
  input  logic [ADDR_BITS-1:0]    addr_neg,
  input  logic                    t_in,
  input  logic                    t_out,
  input  logic                    mc_start,
  input  logic                    dp,
`ifdef TANK_DECODER_LONG_EN
  input  logic                    long_wd,
`endif
  output logic [2**ADDR_BITS-1:0] tank_in,
  output logic [2**ADDR_BITS-1:0] tank_out,
  output logic                    busy,
  output logic                    done,
  output logic                    rail_err
);

  localparam int TANKS = 2**ADDR_BITS;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_SHORT = CNT_W'(WORD_TIME - 1);
`ifdef TANK_DECODER_LONG_EN
  localparam logic [CNT_W-1:0] LAST_LONG  = CNT_W'(2 * WORD_TIME - 1);
`endif

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SYNC = 2'd1,
    XFER      = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n, last_cnt;
  logic [ADDR_BITS-1:0] addr_r, addr_n;
  logic                 dir_in, dir_in_n;
  logic                 err_n, busy_n, done_n, rails_ok;
  logic [TANKS-1:0]     sel, tank_in_n, tank_out_n;
`ifdef TANK_DECODER_LONG_EN
  logic                 long_r, long_n;
`endif

  assign rails_ok = (addr_neg == ~addr_pos);
  assign sel      = {{(TANKS-1){1'b0}}, 1'b1} << addr_r;

`ifdef TANK_DECODER_LONG_EN
  assign last_cnt = long_r ? LAST_LONG : LAST_SHORT;
`else
  assign last_cnt = LAST_SHORT;
`endif

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    addr_n   = addr_r;
    dir_in_n = dir_in;
    err_n    = rail_err;
`ifdef TANK_DECODER_LONG_EN
    long_n   = long_r;
`endif
    case (state)
      IDLE: begin
        if (t_in || t_out) begin
          if ((t_in && t_out) || !rails_ok) begin
            err_n = 1'b1;
          end else begin
            addr_n   = addr_pos;
            dir_in_n = t_in;
`ifdef TANK_DECODER_LONG_EN
            long_n   = long_wd;
`endif
            state_n  = WAIT_SYNC;
          end
        end else begin
          state_n = IDLE;
        end
      end
      WAIT_SYNC: begin
        if (mc_start) begin
          state_n = XFER;
          cnt_n   = {CNT_W{1'b0}};
        end else begin
          state_n = WAIT_SYNC;
        end
      end
      XFER: begin
        // Only digit pulses advance the transfer; mc_start is ignored here.
        if (dp) begin
          cnt_n = cnt + CNT_ONE;
          if (cnt == last_cnt) begin
            state_n = DONE;
          end else begin
            state_n = XFER;
          end
        end else begin
          state_n = XFER;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Outputs are precomputed from the next state so they can be registered.
    busy_n     = (state_n != IDLE);
    done_n     = (state_n == DONE);
    tank_in_n  = (state_n == XFER &&  dir_in) ? sel : {TANKS{1'b0}};
    tank_out_n = (state_n == XFER && !dir_in) ? sel : {TANKS{1'b0}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= {CNT_W{1'b0}};
      addr_r   <= {ADDR_BITS{1'b0}};
      dir_in   <= 1'b0;
      tank_in  <= {TANKS{1'b0}};
      tank_out <= {TANKS{1'b0}};
      busy     <= 1'b0;
      done     <= 1'b0;
      rail_err <= 1'b0;
`ifdef TANK_DECODER_LONG_EN
      long_r   <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      addr_r   <= addr_n;
      dir_in   <= dir_in_n;
      tank_in  <= tank_in_n;
      tank_out <= tank_out_n;
      busy     <= busy_n;
      done     <= done_n;
      rail_err <= err_n;
`ifdef TANK_DECODER_LONG_EN
      long_r   <= long_n;
`endif
    end
  end

endmodule

// File: tb/tb_tank_decoder_seq.sv
// Directed self-checking bench for tank_decoder_seq (ADDR_BITS=2, WORD_TIME=18).
module tb_tank_decoder_seq;

  logic       clk = 1'b0;
  logic       rst, t_in, t_out, mc_start, dp;
  logic [1:0] addr_pos, addr_neg;
  logic [3:0] tank_in, tank_out;
  logic       busy, done, rail_err;
`ifdef TANK_DECODER_LONG_EN
  logic       long_wd;
`endif

  int err_cnt = 0;
  int chk_cnt = 0;

  tank_decoder_seq #(.ADDR_BITS(2), .WORD_TIME(18), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .addr_pos(addr_pos), .addr_neg(addr_neg),
    .t_in(t_in), .t_out(t_out), .mc_start(mc_start), .dp(dp),
`ifdef TANK_DECODER_LONG_EN
    .long_wd(long_wd),
`endif
    .tank_in(tank_in), .tank_out(tank_out), .busy(busy), .done(done),
    .rail_err(rail_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock and settle past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Issue n digit pulses with a gap after each but the last; select must hold.
  task automatic dp_run(input int n, input logic [3:0] exp_in, input logic [3:0] exp_out);
    for (int i = 0; i < n; i++) begin
      dp = 1'b1;
      step();
      dp = 1'b0;
      if (i < n - 1) begin
        check("xfer_tank_in", tank_in, exp_in);
        check("xfer_tank_out", tank_out, exp_out);
        check("xfer_done", done, 1'b0);
        step();
      end
    end
  endtask

  initial begin
    rst = 1'b1; t_in = 1'b0; t_out = 1'b0; mc_start = 1'b0; dp = 1'b0;
    addr_pos = 2'b00; addr_neg = 2'b11;
`ifdef TANK_DECODER_LONG_EN
    long_wd = 1'b0;
`endif
    step(); step();
    check("rst_tank_in", tank_in, 4'b0000);
    check("rst_tank_out", tank_out, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rail_err", rail_err, 1'b0);
    rst = 1'b0;
    step();

    // Write to tank 2.
    addr_pos = 2'b10; addr_neg = 2'b01; t_in = 1'b1;
    step();
    t_in = 1'b0;
    check("t1_busy", busy, 1'b1);
    check("t1_wait_sel", tank_in, 4'b0000);
    step();
    check("t1_wait_sel2", tank_in, 4'b0000);
    mc_start = 1'b1;
    step();
    mc_start = 1'b0;
    check("t1_sel_in", tank_in, 4'b0100);
    check("t1_sel_out", tank_out, 4'b0000);
    dp_run(18, 4'b0100, 4'b0000);
    check("t1_end_sel", tank_in, 4'b0000);
    check("t1_done", done, 1'b1);
    check("t1_busy_done", busy, 1'b1);
    step();
    check("t1_done_clr", done, 1'b0);
    check("t1_busy_clr", busy, 1'b0);

    // Invalid rails with t_out.
    addr_pos = 2'b11; addr_neg = 2'b01; t_out = 1'b1;
    step();
    t_out = 1'b0;
    check("t2_busy", busy, 1'b0);
    check("t2_rail_err", rail_err, 1'b1);
    mc_start = 1'b1;
    step();
    mc_start = 1'b0;
    step();
    check("t2_sel_out", tank_out, 4'b0000);
    check("t2_err_hold", rail_err, 1'b1);
    reset_dut();
    check("t2_err_rst", rail_err, 1'b0);

    // Both strobes with a valid address 0.
    addr_pos = 2'b00; addr_neg = 2'b11; t_in = 1'b1; t_out = 1'b1;
    step();
    t_in = 1'b0; t_out = 1'b0;
    check("t3_rail_err", rail_err, 1'b1);
    check("t3_busy", busy, 1'b0);
    mc_start = 1'b1;
    step();
    mc_start = 1'b0;
    check("t3_sel_in", tank_in, 4'b0000);
    check("t3_sel_out", tank_out, 4'b0000);
    reset_dut();

    // Read tank 1; mc_start coincident with acceptance must not start XFER.
    addr_pos = 2'b01; addr_neg = 2'b10; t_out = 1'b1; mc_start = 1'b1;
    step();
    t_out = 1'b0; mc_start = 1'b0;
    check("t4_busy", busy, 1'b1);
    step();
    check("t4_no_early", tank_out, 4'b0000);
    mc_start = 1'b1;
    step();
    mc_start = 1'b0;
    check("t4_sel_out", tank_out, 4'b0010);
    dp_run(3, 4'b0000, 4'b0010);
    step();
    addr_pos = 2'b11; addr_neg = 2'b00; t_in = 1'b1; mc_start = 1'b1;
    step();
    t_in = 1'b0; mc_start = 1'b0;
    check("t4_ignore_in", tank_in, 4'b0000);
    check("t4_ignore_out", tank_out, 4'b0010);
    check("t4_no_err", rail_err, 1'b0);
    dp_run(15, 4'b0000, 4'b0010);
    check("t4_done", done, 1'b1);
    check("t4_end_sel", tank_out, 4'b0000);
    step();
    mc_start = 1'b1;
    step();
    mc_start = 1'b0;
    step();
    check("t4_idle_busy", busy, 1'b0);
    check("t4_idle_in", tank_in, 4'b0000);
    check("t4_idle_out", tank_out, 4'b0000);

    // Reset in the middle of XFER.
    addr_pos = 2'b00; addr_neg = 2'b11; t_in = 1'b1;
    step();
    t_in = 1'b0;
    mc_start = 1'b1;
    step();
    mc_start = 1'b0;
    check("t5_sel", tank_in, 4'b0001);
    dp_run(7, 4'b0001, 4'b0000);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_rst_sel", tank_in, 4'b0000);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_done", done, 1'b0);
    dp = 1'b1;
    step();
    dp = 1'b0;
    check("t5_after_done", done, 1'b0);
    check("t5_after_sel", tank_in, 4'b0000);

`ifdef TANK_DECODER_LONG_EN
    // Long word to tank 0: 36 digit pulses.
    addr_pos = 2'b00; addr_neg = 2'b11; t_in = 1'b1; long_wd = 1'b1;
    step();
    t_in = 1'b0; long_wd = 1'b0;
    mc_start = 1'b1;
    step();
    mc_start = 1'b0;
    check("t6_sel", tank_in, 4'b0001);
    dp_run(36, 4'b0001, 4'b0000);
    check("t6_done", done, 1'b1);
    check("t6_end_sel", tank_in, 4'b0000);
    step();
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
